// File: rtl/posit_encoder.sv
// posit_encoder: two-stage posit packer (inverse of the posit decoder).
//   Stage 1 builds the unsigned regime/exponent/fraction bitstring and settles
//   regime saturation. Stage 2 rounds to WIDTH-1 magnitude bits, applies the
//   sign and the zero/NaR specials, and holds the result under backpressure.
// Optional feature macro: POSIT_ENCODER_RNE_EN
//   defined   -> round-to-nearest-even
//   undefined -> truncation
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   in_valid / in_ready         input handshake (in_ready is combinational from out_ready)
//   sign, regime, exponent,
//   mantissa, is_zero, is_nar   input fields
//   out_valid / out_ready, q    output handshake and encoded posit
module posit_encoder #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic signed [7:0] regime,
  input  logic signed [7:0] exponent,
  input  logic [7:0]        mantissa,
  input  logic              is_zero,
  input  logic              is_nar,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  q
);

  localparam int unsigned MW = WIDTH - 1;          // magnitude bits
  localparam int unsigned BW = EN + 8;             // exponent + fraction bits
  localparam int unsigned FW = WIDTH - 1 + EN + 10; // stage-1 bitstring width
  localparam int          KMAX = int'(WIDTH) - 2;
  localparam int          KMIN = -(int'(WIDTH) - 1);

  // Stage 1 state
  logic          s1_valid_q, s1_valid_d;
  logic [FW-1:0] field_q, field_d;
  logic          neg_q, neg_d;
  logic          zero_q, zero_d;
  logic          nar_q, nar_d;

  // Stage 2 (output) state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic s1_load_c;
  logic s2_load_c;

  // Handshake: S2 refills when it is empty or being drained; S1 can then accept.
  assign s2_load_c = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready  = ~s1_valid_q | s2_load_c;
  assign s1_load_c = in_valid & in_ready;

  // Stage 1: regime run + exponent + fraction, left-aligned, with saturation
  logic [15:0]       body_wide_c;
  logic [BW-1:0]     body_c;
  logic [FW-1:0]     body_al_c;
  logic [FW-1:0]     regime_bits_c;
  logic [FW-1:0]     built_c;
  int                k_c;
  int unsigned       run_len_c;
  int unsigned       ones_c;
  int unsigned       one_pos_c;

  always_comb begin
    body_wide_c   = {exponent, mantissa};
    body_c        = body_wide_c[BW-1:0];
    body_al_c     = {body_c, {(FW-BW){1'b0}}};
    k_c           = int'(regime);
    run_len_c     = 32'd0;
    ones_c        = 32'd0;
    one_pos_c     = 32'd0;
    regime_bits_c = '0;
    built_c       = '0;
    if (k_c >= KMAX) begin
      built_c = {{MW{1'b1}}, {(FW-MW){1'b0}}};
    end else if (k_c <= KMIN) begin
      built_c = FW'(1) << (FW - MW);
    end else begin
      if (k_c >= 0) begin
        // k+1 ones then a terminating zero
        ones_c        = 32'(k_c + 1);
        run_len_c     = 32'(k_c + 2);
        regime_bits_c = ~({FW{1'b1}} >> ones_c);
      end else begin
        // -k zeros then a terminating one
        run_len_c     = 32'(1 - k_c);
        one_pos_c     = 32'(int'(FW) - 1 + k_c);
        regime_bits_c = FW'(1) << one_pos_c;
      end
      built_c = regime_bits_c | (body_al_c >> run_len_c);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    field_d    = field_q;
    neg_d      = neg_q;
    zero_d     = zero_q;
    nar_d      = nar_q;
    if (s1_load_c) begin
      s1_valid_d = 1'b1;
      field_d    = built_c;
      neg_d      = sign;
      zero_d     = is_zero;
      nar_d      = is_nar;
    end else if (s2_load_c) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: round, clamp to [minpos, maxpos], apply sign and specials
  logic [MW-1:0]    kept_c;
  logic             inc_c;
  logic [WIDTH-1:0] rounded_c;
  logic [MW-1:0]    mag_c;
  logic [WIDTH-1:0] signed_c;
  logic [WIDTH-1:0] enc_c;

  assign kept_c = field_q[FW-1 -: MW];

`ifdef POSIT_ENCODER_RNE_EN
  logic guard_c;
  logic sticky_c;
  assign guard_c  = field_q[FW-MW-1];
  assign sticky_c = |field_q[FW-MW-2:0];
  assign inc_c    = guard_c & (sticky_c | kept_c[0]);
`else
  logic unused_round_bits;
  assign unused_round_bits = ^field_q[FW-MW-1:0];
  assign inc_c             = 1'b0;
`endif

  always_comb begin
    rounded_c = {1'b0, kept_c} + WIDTH'(inc_c);
    if (rounded_c[WIDTH-1]) begin
      mag_c = {MW{1'b1}};
    end else if (rounded_c[MW-1:0] == '0) begin
      mag_c = MW'(1);
    end else begin
      mag_c = rounded_c[MW-1:0];
    end
    signed_c = neg_q ? (~{1'b0, mag_c} + WIDTH'(1)) : {1'b0, mag_c};
    if (nar_q) begin
      enc_c = {1'b1, {MW{1'b0}}};
    end else if (zero_q) begin
      enc_c = '0;
    end else begin
      enc_c = signed_c;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    q_d         = q_q;
    if (s2_load_c) begin
      out_valid_d = 1'b1;
      q_d         = enc_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      field_q     <= '0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      nar_q       <= 1'b0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      field_q     <= field_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      nar_q       <= nar_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
    end
  end

  assign out_valid = out_valid_q;
  assign q         = q_q;

endmodule

// File: tb/tb_posit_encoder.sv
// Directed + scoreboard testbench for posit_encoder (WIDTH=7, EN=1).
module tb_posit_encoder;

  localparam int W  = 7;
  localparam int EN = 1;

`ifdef POSIT_ENCODER_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              sign;
  logic signed [7:0] regime;
  logic signed [7:0] exponent;
  logic [7:0]        mantissa;
  logic              is_zero;
  logic              is_nar;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      q;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];

  posit_encoder #(.WIDTH(W), .EN(EN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .regime(regime), .exponent(exponent), .mantissa(mantissa),
    .is_zero(is_zero), .is_nar(is_nar), .out_valid(out_valid),
    .out_ready(out_ready), .q(q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference: append regime, exponent, fraction, then round.
  function automatic logic [W-1:0] model(input logic s, input int k, input int e,
                                         input int m, input logic z, input logic n);
    longint bits;
    int     len;
    int     sh;
    longint mag;
    bit     guard, sticky;
    if (n) return 7'h40;
    if (z) return 7'h00;
    if (k >= W - 2) mag = (1 << (W - 1)) - 1;
    else if (k <= -(W - 1)) mag = 1;
    else begin
      bits = 0; len = 0;
      if (k >= 0) begin
        for (int i = 0; i < k + 1; i++) begin bits = (bits << 1) | 1; len++; end
        bits = bits << 1; len++;
      end else begin
        for (int i = 0; i < -k; i++) begin bits = bits << 1; len++; end
        bits = (bits << 1) | 1; len++;
      end
      for (int i = EN - 1; i >= 0; i--) begin bits = (bits << 1) | longint'((e >> i) & 1); len++; end
      bits = (bits << 8) | longint'(m & 8'hFF); len += 8;
      sh     = len - (W - 1);
      mag    = bits >> sh;
      guard  = ((bits >> (sh - 1)) & 1) != 0;
      sticky = (bits & ((longint'(1) << (sh - 1)) - 1)) != 0;
      if (RNE && guard && (sticky || (mag & 1) != 0)) mag++;
      if (mag >= (1 << (W - 1))) mag = (1 << (W - 1)) - 1;
      if (mag == 0) mag = 1;
    end
    return s ? W'(-mag) : W'(mag);
  endfunction

  // Output monitor: pop and compare each transferred word.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      chk("unexpected_output", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("q_scoreboard", 32'(q), 32'(sb.pop_front()));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic s, input int k, input int e, input int m,
                      input logic z, input logic n, input logic [W-1:0] exp);
    bit acc = 0;
    int cnt = 0;
    sign = s; regime = 8'(k); exponent = 8'(e); mantissa = 8'(m);
    is_zero = z; is_nar = n; in_valid = 1'b1;
    while (!acc && cnt < 50) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; sb.push_back(exp); end
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int cnt = 0;
    while (sb.size() > 0 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; sign = 1'b0; regime = '0; exponent = '0;
    mantissa = '0; is_zero = 1'b0; is_nar = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_q", 32'(q), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Latency: out_valid one edge after the accept edge is still low, then high.
    send(1'b0, 0, 0, 8'h00, 1'b0, 1'b0, 7'h20);
    chk("latency_s1_only", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_q", 32'(q), 32'h20);
    drain();

    // Basic values
    send(1'b0, 0, 1, 8'h80, 1'b0, 1'b0, 7'h2C);
    send(1'b1, 0, 0, 8'h00, 1'b0, 1'b0, 7'h60);
    // Rounding
    send(1'b0, 0, 0, 8'h18, 1'b0, 1'b0, RNE ? 7'h21 : 7'h20);
    send(1'b0, 0, 0, 8'h10, 1'b0, 1'b0, 7'h20);
    send(1'b0, 0, 0, 8'h30, 1'b0, 1'b0, RNE ? 7'h22 : 7'h21);
    // Saturation
    send(1'b0, 5, 1, 8'h00, 1'b0, 1'b0, 7'h3F);
    send(1'b0, -6, 0, 8'h00, 1'b0, 1'b0, 7'h01);
    send(1'b1, 7, 0, 8'h00, 1'b0, 1'b0, 7'h41);
    send(1'b0, 4, 1, 8'hFF, 1'b0, 1'b0, RNE ? 7'h3F : 7'h3E);
    // Specials
    send(1'b0, 2, 1, 8'h55, 1'b1, 1'b0, 7'h00);
    send(1'b1, 2, 1, 8'h55, 1'b1, 1'b1, 7'h40);
    drain();

    // Backpressure: three words, consumer stalled for 3 cycles
    out_ready = 1'b0;
    sign = 1'b0; regime = 8'sd0; exponent = 8'sd0; mantissa = 8'h00;
    is_zero = 1'b0; is_nar = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready_1", 32'(in_ready), 32'd1);
    sb.push_back(7'h20);
    @(posedge clk); #1;
    exponent = 8'sd1; mantissa = 8'h80;
    @(negedge clk);
    chk("bp_ready_2", 32'(in_ready), 32'd1);
    sb.push_back(7'h2C);
    @(posedge clk); #1;
    sign = 1'b1; exponent = 8'sd0; mantissa = 8'h00;
    @(negedge clk);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_hold_q_a", 32'(q), 32'h20);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_low_2", 32'(in_ready), 32'd0);
    chk("bp_hold_q_b", 32'(q), 32'h20);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_release", 32'(in_ready), 32'd1);
    sb.push_back(7'h60);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_consecutive", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    drain();

    // Reset with two words in flight
    out_ready = 1'b0;
    send(1'b0, 1, 0, 8'h00, 1'b0, 1'b0, 7'h30);
    send(1'b0, 2, 0, 8'h00, 1'b0, 1'b0, 7'h38);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_q", 32'(q), 32'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_emit", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    send(1'b1, 0, 1, 8'h80, 1'b0, 1'b0, 7'h54);
    drain();

    // Pseudo-random fields against the reference model
    for (int i = 0; i < 24; i++) begin
      logic s, z, n;
      int k, e, m;
      s = 1'($urandom_range(0, 1));
      k = int'($urandom_range(0, 16)) - 8;
      e = int'($urandom_range(0, 1));
      m = int'($urandom_range(0, 255));
      z = ($urandom_range(0, 9) == 0);
      n = ($urandom_range(0, 9) == 0);
      send(s, k, e, m, z, n, model(s, k, e, m, z, n));
    end
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
